// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MiniMIPS instruction-fetch sequencer.
package mips_fetch_pkg;

  localparam int unsigned PcWidthDefault    = 32;
  localparam int unsigned InstrWidthDefault = 16;
  localparam logic [3:0]  HaltOpcodeDefault = 4'b1111;
  localparam int unsigned OpcodeMsb         = 15;
  localparam int unsigned OpcodeLsb         = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips_pc_register.sv
// Program counter: synchronous reset, redirect load and wrap-around increment.
module mips_pc_register #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [PC_WIDTH-1:0] load_pc_i,
  input  logic                incr_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (incr_i) begin
      pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch sequencer: drives imem address from the PC and registers words into a
// valid/ready stage for decode, with redirect flush and halt detection.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PcWidthDefault,
  parameter int unsigned         INSTR_WIDTH = InstrWidthDefault,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = HaltOpcodeDefault,
  parameter int unsigned         CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  fetch_state_e            state_d, state_q;
  logic                    valid_d, valid_q;
  logic [INSTR_WIDTH-1:0]  instr_d, instr_q;
  logic [PC_WIDTH-1:0]     opc_d, opc_q;
  logic                    halted_d, halted_q;
  logic [CNT_WIDTH-1:0]    cnt_d, cnt_q;
  logic [PC_WIDTH-1:0]     pc;
  logic                    pc_load, pc_incr;
  logic                    load, is_halt;

  assign load    = !valid_q || out_ready;
  assign is_halt = (imem_data[OpcodeMsb:OpcodeLsb] == HALT_OPCODE);

  mips_pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc),
    .incr_i    (pc_incr),
    .pc_o      (pc)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    halted_d = halted_q;
    pc_load  = 1'b0;
    pc_incr  = 1'b0;
    cnt_d    = cnt_q;
    if (valid_q && out_ready) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    unique case (state_q)
      StIdle: begin
        pc_load = redirect_valid;
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (load) begin
          instr_d = imem_data;
          opc_d   = pc;
          valid_d = 1'b1;
          if (is_halt) begin
            // PC stays on the halt word so imem_addr freezes there.
            state_d  = StHalt;
            halted_d = 1'b1;
          end else begin
            pc_incr = 1'b1;
          end
        end
      end
      StHalt: begin
        if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr   = pc;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule
